// File: rtl/bus_ctrl_if.sv
// bus_ctrl_if: CPU memory-bus strobes/data plus peripheral req/ack signals of bus_ctrl
interface bus_ctrl_if;
  logic       read;
  logic       write;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       bus_err;
  logic       io_read;
  logic       io_write;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_ack;
  modport master (
    output read, write, address, data_in, io_rdata, io_ack,
    input  data_out, ready, bus_err, io_read, io_write, io_addr, io_wdata
  );
  modport slave (
    input  read, write, address, data_in, io_rdata, io_ack,
    output data_out, ready, bus_err, io_read, io_write, io_addr, io_wdata
  );
endinterface

// File: rtl/bus_ctrl.sv
// bus_ctrl: CPU bus decoder to internal RAM and req/ack I/O window; optional BUS_WRITE_PROTECT_EN makes RAM below PROT_LIMIT read-only
module bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  IO_BASE     = 8'hF0,
  parameter int unsigned IO_TIMEOUT  = 15,
  parameter logic [7:0]  PROT_LIMIT  = 8'h40
) (
  input logic     clk,
  input logic     reset,
  bus_ctrl_if.slave b
);
  typedef enum logic [1:0] {IDLE, WAIT, IO, RESP} state_t;
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] tcnt, tcnt_n;
  logic [7:0] addr_q, addr_n, wdata_q, wdata_n;
  logic       wr_q, wr_n;
  logic [7:0] data_n, io_addr_n, io_wdata_n;
  logic       ready_n, err_n, io_read_n, io_write_n;
  logic       ram_go, ram_we, acc_wr;
  logic [7:0] acc_addr, acc_wdata;
  logic [7:0] mem [IO_BASE];
`ifdef BUS_WRITE_PROTECT_EN
  wire prot = acc_addr < PROT_LIMIT;
`else
  wire prot = 1'b0;
  logic unused_prot;
  assign unused_prot = ^PROT_LIMIT;
`endif
  // next-state, next-output and RAM access decode
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tcnt_n     = tcnt;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    wr_n       = wr_q;
    data_n     = b.data_out;
    err_n      = 1'b0;
    io_read_n  = b.io_read;
    io_write_n = b.io_write;
    io_addr_n  = b.io_addr;
    io_wdata_n = b.io_wdata;
    ram_go     = 1'b0;
    acc_addr   = addr_q;
    acc_wr     = wr_q;
    acc_wdata  = wdata_q;
    case (state)
      IDLE: begin
        if (b.read && b.write) begin
          err_n = 1'b1;
        end else if (b.read ^ b.write) begin
          addr_n  = b.address;
          wdata_n = b.data_in;
          wr_n    = b.write;
          if (b.address >= IO_BASE) begin
            state_n    = IO;
            io_read_n  = b.read;
            io_write_n = b.write;
            io_addr_n  = b.address - IO_BASE;
            io_wdata_n = b.data_in;
            tcnt_n     = 8'd0;
          end else begin
            cnt_n     = 4'(WAIT_CYCLES);
            state_n   = WAIT_CYCLES > 0 ? WAIT : RESP;
            ram_go    = WAIT_CYCLES == 0;
            acc_addr  = b.address;
            acc_wr    = b.write;
            acc_wdata = b.data_in;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = RESP;
          ram_go  = 1'b1;
        end
      end
      IO: begin
        if (b.io_ack) begin
          io_read_n  = 1'b0;
          io_write_n = 1'b0;
          data_n     = wr_q ? b.data_out : b.io_rdata;
          state_n    = RESP;
        end else if (tcnt == 8'(IO_TIMEOUT - 1)) begin
          io_read_n  = 1'b0;
          io_write_n = 1'b0;
          data_n     = wr_q ? b.data_out : 8'hFF;
          err_n      = 1'b1;
          state_n    = RESP;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (ram_go) begin
      data_n = acc_wr ? data_n : mem[acc_addr];
      err_n  = err_n | (acc_wr & prot);
    end
    ram_we  = ram_go & acc_wr & ~prot;
    ready_n = state_n == RESP;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      tcnt       <= 8'd0;
      addr_q     <= 8'd0;
      wdata_q    <= 8'd0;
      wr_q       <= 1'b0;
      b.data_out <= 8'h00;
      b.ready    <= 1'b0;
      b.bus_err  <= 1'b0;
      b.io_read  <= 1'b0;
      b.io_write <= 1'b0;
      b.io_addr  <= 8'h00;
      b.io_wdata <= 8'h00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tcnt       <= tcnt_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      wr_q       <= wr_n;
      b.data_out <= data_n;
      b.ready    <= ready_n;
      b.bus_err  <= err_n;
      b.io_read  <= io_read_n;
      b.io_write <= io_write_n;
      b.io_addr  <= io_addr_n;
      b.io_wdata <= io_wdata_n;
    end
  end
  // RAM write on the edge entering RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && ram_we) mem[acc_addr] <= acc_wdata;
  end
endmodule
